fp_accumulate: RTL and testbench

- Sequential FP32 accumulator directly downstream of the fp_multiply stage.
- Consumes a stream of IEEE-754 single-precision products and sums them one at a time with a multi-cycle FSM adder.
- Emits the frame sum and element count when the element flagged last has been added.
- Forms the reduction half of the dot-product/MAC path.

---
 rtl/fp_accumulate.sv | 254 +++++++++++++++++++++++++
 tb/tb_fp_accumulate.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fp_accumulate.sv
// fp_accumulate: sequential FP32 accumulator for the reduction half of the
// dot-product/MAC path. Each accepted product is added to a running sum by a
// small FSM adder (ALIGN -> ADD -> NORM). The frame sum and element count are
// presented on the output once the element flagged last has been added.
// Denormals flush to zero and rounding is truncation.

module fp_accumulate #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_OUT   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        op_q, op_d;
  logic               last_q, last_d;
  logic               nan_q, nan_d;
  logic               sign_q, sign_d;
  logic [7:0]         exp_q, exp_d;
  logic [24:0]        mant_q, mant_d;    // large mantissa, later the raw sum
  logic [23:0]        mants_q, mants_d;  // aligned small mantissa
  logic               sub_q, sub_d;
  logic               in_ready_q;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  // Unpacked fields of the accumulator (a) and the latched operand (b).
  logic        a_sign_s, b_sign_s;
  logic [7:0]  a_exp_s, b_exp_s;
  logic [22:0] a_frac_s, b_frac_s;
  logic        a_zero_s, b_zero_s, a_inf_s, b_inf_s, b_nan_s, a_ge_b_s;
  logic [7:0]  diff_s;
  logic [23:0] small_mant_s, shifted_s;
  logic [24:0] sum_s;
  logic        fin_s;
  logic [31:0] res_s;

  assign a_sign_s = acc_q[31];
  assign a_exp_s  = acc_q[30:23];
  assign a_frac_s = acc_q[22:0];
  assign b_sign_s = op_q[31];
  assign b_exp_s  = op_q[30:23];
  assign b_frac_s = op_q[22:0];

  // exp==0 counts as zero so denormals flush; the accumulator never holds a NaN.
  assign a_zero_s = (a_exp_s == 8'd0);
  assign b_zero_s = (b_exp_s == 8'd0);
  assign a_inf_s  = (a_exp_s == 8'hFF);
  assign b_inf_s  = (b_exp_s == 8'hFF) && (b_frac_s == 23'd0);
  assign b_nan_s  = (b_exp_s == 8'hFF) && (b_frac_s != 23'd0);
  assign a_ge_b_s = ({a_exp_s, a_frac_s} >= {b_exp_s, b_frac_s});

  assign diff_s       = a_ge_b_s ? (a_exp_s - b_exp_s) : (b_exp_s - a_exp_s);
  assign small_mant_s = a_ge_b_s ? {1'b1, b_frac_s} : {1'b1, a_frac_s};
  assign shifted_s    = (diff_s >= 8'd25) ? 24'd0 : (small_mant_s >> diff_s);

  assign sum_s = sub_q ? ({1'b0, mant_q[23:0]} - {1'b0, mants_q})
                       : ({1'b0, mant_q[23:0]} + {1'b0, mants_q});

  // Next-state logic: FSM transitions, datapath updates and result write-back.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    op_d        = op_q;
    last_d      = last_q;
    nan_d       = nan_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    mants_d     = mants_q;
    sub_d       = sub_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    fin_s       = 1'b0;
    res_s       = acc_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d    = in_data;
          last_d  = in_last;
          count_d = (count_q == {CNT_W{1'b1}}) ? count_q : (count_q + CNT_W'(1));
          state_d = S_ALIGN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ALIGN: begin
        if (b_nan_s) begin
          nan_d = 1'b1;
          fin_s = 1'b1;
          res_s = acc_q;
        end else if (a_inf_s && b_inf_s && (a_sign_s != b_sign_s)) begin
          nan_d = 1'b1;
          fin_s = 1'b1;
          res_s = acc_q;
        end else if (a_inf_s) begin
          fin_s = 1'b1;
          res_s = acc_q;
        end else if (b_inf_s) begin
          fin_s = 1'b1;
          res_s = op_q;
        end else if (b_zero_s) begin
          fin_s = 1'b1;
          res_s = acc_q;
        end else if (a_zero_s) begin
          fin_s = 1'b1;
          res_s = op_q;
        end else begin
          sign_d  = a_ge_b_s ? a_sign_s : b_sign_s;
          exp_d   = a_ge_b_s ? a_exp_s : b_exp_s;
          mant_d  = a_ge_b_s ? {2'b01, a_frac_s} : {2'b01, b_frac_s};
          mants_d = shifted_s;
          sub_d   = a_sign_s ^ b_sign_s;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        if (sum_s == 25'd0) begin
          fin_s = 1'b1;
          res_s = 32'h0000_0000;
        end else if (sum_s[24:23] == 2'b01) begin
          // Already normalized: no NORM cycle needed.
          fin_s = 1'b1;
          res_s = {sign_q, exp_q, sum_s[22:0]};
        end else begin
          mant_d  = sum_s;
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (mant_q[24]) begin
          if (exp_q == 8'd254) begin
            fin_s = 1'b1;
            res_s = {sign_q, 8'hFF, 23'd0};
          end else begin
            fin_s = 1'b1;
            res_s = {sign_q, exp_q + 8'd1, mant_q[23:1]};
          end
        end else if (exp_q == 8'd1) begin
          // Next left shift would reach exp 0: flush.
          fin_s = 1'b1;
          res_s = 32'h0000_0000;
        end else if (mant_q[22]) begin
          fin_s = 1'b1;
          res_s = {sign_q, exp_q - 8'd1, mant_q[21:0], 1'b0};
        end else begin
          mant_d = {mant_q[23:0], 1'b0};
          exp_d  = exp_q - 8'd1;
        end
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = 32'h0000_0000;
          count_d     = {CNT_W{1'b0}};
          nan_d       = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Exit point: commit the element result and either publish or return.
    if (fin_s) begin
      acc_d = res_s;
      if (last_q) begin
        state_d     = S_OUT;
        out_valid_d = 1'b1;
        out_data_d  = nan_d ? QNAN : res_s;
        out_count_d = count_q;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      res_s = acc_d;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      acc_q       <= 32'h0000_0000;
      count_q     <= {CNT_W{1'b0}};
      op_q        <= 32'h0000_0000;
      last_q      <= 1'b0;
      nan_q       <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= 8'd0;
      mant_q      <= 25'd0;
      mants_q     <= 24'd0;
      sub_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      op_q        <= op_d;
      last_q      <= last_d;
      nan_q       <= nan_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      mants_q     <= mants_d;
      sub_q       <= sub_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_fp_accumulate.sv
// Directed testbench for fp_accumulate: frames of FP32 values with
// hand-computed sums, latency checks, back-pressure and mid-frame reset.

module tb_fp_accumulate;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_valid;
  logic             out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  always #5 clk = ~clk;

  fp_accumulate #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; waits (bounded) for in_ready, then transfers one element.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_timeout", {31'd0, (n >= 50)}, 32'd0);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Counts negedges until out_valid; lat is measured from the negedge after the last accept.
  task automatic wait_result(output int l);
    l = 0;
    while (out_valid !== 1'b1 && l < 100) begin
      @(negedge clk);
      l++;
    end
    check("out_valid_timeout", {31'd0, (l >= 100)}, 32'd0);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic expect_frame(input string tag, input logic [31:0] d, input logic [CNT_W-1:0] c);
    wait_result(lat);
    check({tag, "_data"}, out_data, d);
    check({tag, "_count"}, {16'd0, out_count}, {16'd0, c});
    handshake();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_data   = 32'h0000_0000;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_data", out_data, 32'h0000_0000);
    check("rst_out_count", {16'd0, out_count}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // 1 + 2 + 3 = 6; last add needs one right-shift NORM cycle.
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    send(32'h4040_0000, 1'b1);
    wait_result(lat);
    check("sum6_latency", lat, 32'd3);
    check("sum6_data", out_data, 32'h40C0_0000);
    check("sum6_count", {16'd0, out_count}, 32'd3);
    handshake();
    check("sum6_data_held", out_data, 32'h40C0_0000);

    // Exact cancellation resolves in ADD to +0.
    send(32'h3FC0_0000, 1'b0);
    send(32'hBFC0_0000, 1'b1);
    wait_result(lat);
    check("cancel_latency", lat, 32'd2);
    check("cancel_data", out_data, 32'h0000_0000);
    check("cancel_count", {16'd0, out_count}, 32'd2);
    handshake();

    // 1.0 - 0.75 = 0.25 with two left-shift NORM cycles.
    send(32'h3F80_0000, 1'b0);
    send(32'hBF40_0000, 1'b1);
    wait_result(lat);
    check("quarter_latency", lat, 32'd4);
    check("quarter_data", out_data, 32'h3E80_0000);
    check("quarter_count", {16'd0, out_count}, 32'd2);
    handshake();

    send(32'h3F80_0000, 1'b0);
    send(32'h7FC0_0001, 1'b0);
    send(32'h4000_0000, 1'b1);
    expect_frame("nan_in", 32'h7FC0_0000, 16'd3);

    send(32'h7F80_0000, 1'b0);
    send(32'hFF80_0000, 1'b1);
    expect_frame("inf_minus_inf", 32'h7FC0_0000, 16'd2);

    send(32'h7F7F_FFFF, 1'b0);
    send(32'h7F7F_FFFF, 1'b1);
    expect_frame("overflow", 32'h7F80_0000, 16'd2);

    send(32'h7F80_0000, 1'b0);
    send(32'h3F80_0000, 1'b1);
    expect_frame("inf_plus_one", 32'h7F80_0000, 16'd2);

    // Back-pressure: outputs hold while out_ready stays low.
    send(32'h3F80_0000, 1'b1);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", out_data, 32'h3F80_0000);
      check("bp_out_count", {16'd0, out_count}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    handshake();
    send(32'h4000_0000, 1'b1);
    expect_frame("after_bp", 32'h4000_0000, 16'd1);

    // Reset during a long (23-step) left normalization discards the frame.
    send(32'h3F80_0000, 1'b0);
    send(32'hBF7F_FFFF, 1'b0);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    reset_n = 1'b1;
    send(32'h4000_0000, 1'b1);
    expect_frame("after_rst", 32'h4000_0000, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
